// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared types and constants for the iterative shift unit.
//   shift_mode_t : operation selector (SLL, SRL, SRA, ROR)
//   state_t      : control FSM states
//   MODE_*       : raw 2-bit encodings of the in_mode port
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        SH_SLL = MODE_SLL,
        SH_SRL = MODE_SRL,
        SH_SRA = MODE_SRA,
        SH_ROR = MODE_ROR
    } shift_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Combinational single-step shifter: moves i_value by i_k positions (i_k is
// at most STEP) in the requested direction/mode.
//   i_value : operand
//   i_k     : positions to shift this step (0..STEP)
//   i_mode  : SLL / SRL / SRA / ROR
//   i_fill  : bit injected at the top on right shifts (0 for SRL)
//   o_value : shifted operand
// Build option: SHIFT_ROT_EN adds the rotate-right path; without it ROR
// falls through to the logical right shift and no rotate logic exists.
// -----------------------------------------------------------------------------
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [KW-1:0]    i_k,
    input  shift_mode_t      i_mode,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_value
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] w_right;

    // Top i_k bits come from the fill bit: the inverted right-shifted all-ones
    // mask marks exactly those positions.
    assign w_right = (i_value >> i_k) | (~({WIDTH{1'b1}} >> i_k) & {WIDTH{i_fill}});

`ifdef SHIFT_ROT_EN
    logic [SW:0] w_lamt;

    // Left amount for the wrap-around half; k=0 gives WIDTH, which clears it.
    assign w_lamt = (SW + 1)'(WIDTH) - (SW + 1)'(i_k);
`endif

    // NOTE: every output of a combinational block gets a value on every path
    // (here via the default arm), otherwise synthesis infers a latch.
    always_comb begin
        case (i_mode)
            SH_SLL:         o_value = i_value << i_k;
            SH_SRL, SH_SRA: o_value = w_right;
`ifdef SHIFT_ROT_EN
            SH_ROR:         o_value = (i_value >> i_k) | (i_value << w_lamt);
`endif
            default:        o_value = w_right;
        endcase
    end

endmodule

// File: rtl/shift_unit_iter.sv
// -----------------------------------------------------------------------------
// shift_unit_iter
// Multi-cycle shifter with valid/ready handshakes on both sides. Shifts up to
// STEP bit positions per clock until the requested amount is consumed, then
// presents a registered result and zero flag until the consumer takes it.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   in_valid   : request valid          in_ready  : unit idle and accepting
//   in_a       : operand                in_amt    : amount (low SHW bits used)
//   in_mode    : 00 SLL, 01 SRL, 10 SRA, 11 ROR (SRL unless SHIFT_ROT_EN)
//   out_valid  : result valid           out_ready : consumer accepts result
//   out_result : shifted value          out_zero  : out_result == 0
// Build option: define SHIFT_ROT_EN to enable rotate-right for mode 11.
// -----------------------------------------------------------------------------
module shift_unit_iter
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam int KW  = $clog2(STEP + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_rem;
    shift_mode_t      r_mode;
    logic             r_fill;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_out_valid;

    logic             w_accept;
    logic [SHW-1:0]   w_amt;
    shift_mode_t      w_mode;
    logic [KW-1:0]    w_k;
    logic             w_last;
    logic [WIDTH-1:0] w_shifted;
    logic             w_unused_amt;

    assign in_ready   = (r_state == ST_IDLE) && !rst;
    assign w_accept   = in_valid && in_ready;
    assign w_amt      = in_amt[SHW-1:0];
    // Upper amount bits are ignored: the shift amount wraps modulo WIDTH.
    assign w_unused_amt = ^in_amt[WIDTH-1:SHW];

    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_zero   = r_zero;

`ifdef SHIFT_ROT_EN
    assign w_mode = shift_mode_t'(in_mode);
`else
    assign w_mode = (in_mode == MODE_ROR) ? SH_SRL : shift_mode_t'(in_mode);
`endif

    // Step size is min(STEP, remaining); the last step is the one that
    // consumes everything left.
    always_comb begin
        if (32'(r_rem) < 32'(STEP)) begin
            w_k    = KW'(r_rem);
            w_last = 1'b1;
        end else begin
            w_k    = KW'(STEP);
            w_last = (32'(r_rem) == 32'(STEP));
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .i_value (r_work),
        .i_k     (w_k),
        .i_mode  (r_mode),
        .i_fill  (r_fill),
        .o_value (w_shifted)
    );

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_rem       <= '0;
            r_mode      <= SH_SLL;
            r_fill      <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_work <= in_a;
                        r_rem  <= w_amt;
                        r_mode <= w_mode;
                        // Sign is captured once, so SRA fill survives every step.
                        r_fill <= (w_mode == SH_SRA) && in_a[WIDTH-1];
                        if (w_amt == '0) begin
                            r_result    <= in_a;
                            r_zero      <= (in_a == '0);
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_shifted;
                    r_rem  <= r_rem - SHW'(w_k);
                    if (w_last) begin
                        r_result    <= w_shifted;
                        r_zero      <= (w_shifted == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_iter.sv
// -----------------------------------------------------------------------------
// tb_shift_unit_iter
// Directed self-checking bench for shift_unit_iter (WIDTH=32). Expected
// results are hand-computed; latency expectations follow 1+ceil(amt/STEP).
// -----------------------------------------------------------------------------
module tb_shift_unit_iter;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_unit_iter #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_amt     (in_amt),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] amt);
        int s;
        s = int'(amt % WIDTH);
        return 1 + (s + STEP - 1) / STEP;
    endfunction

    // Issue one request, measure latency, check result, then retire it.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] amt,
                          input logic [1:0] mode, input logic [31:0] exp_res, input logic exp_zero);
        int lat;
        @(negedge clk);
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_amt   = amt;
        in_mode  = mode;
        @(posedge clk); #1;
        // Scramble inputs after accept; the unit must ignore them.
        in_valid = 1'b0;
        in_a     = ~a;
        in_amt   = amt + 32'd7;
        in_mode  = ~mode;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"},  64'(lat),        64'(exp_lat(amt)));
        check({tag, "_res"},  64'(out_result), 64'(exp_res));
        check({tag, "_zero"}, 64'(out_zero),   64'(exp_zero));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_pop_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_pop_rdy"},   64'(in_ready),  64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_amt    = '0;
        in_mode   = 2'b00;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready),   64'd0);
        check("rst_out_valid", 64'(out_valid),  64'd0);
        check("rst_result",    64'(out_result), 64'd0);
        check("rst_zero",      64'(out_zero),   64'd0);
        rst = 1'b0;

        run_op("srl31",    32'h8000_0000, 32'd31,  2'b01, 32'h0000_0001, 1'b0);
        run_op("sra4",     32'h8000_0000, 32'd4,   2'b10, 32'hF800_0000, 1'b0);
        run_op("sll0",     32'h0000_0001, 32'd0,   2'b00, 32'h0000_0001, 1'b0);
        run_op("srl_wrap", 32'h0000_000F, 32'h24,  2'b01, 32'h0000_0000, 1'b1);
        run_op("sra31",    32'h8000_0000, 32'd31,  2'b10, 32'hFFFF_FFFF, 1'b0);
        run_op("sra_pos",  32'h7000_0000, 32'd5,   2'b10, 32'h0380_0000, 1'b0);
        run_op("sll12",    32'h0000_00FF, 32'd12,  2'b00, 32'h000F_F000, 1'b0);
        run_op("sll33",    32'h0000_0001, 32'd33,  2'b00, 32'h0000_0002, 1'b0);
        run_op("srl16",    32'hFFFF_FFFF, 32'd16,  2'b01, 32'h0000_FFFF, 1'b0);
`ifdef SHIFT_ROT_EN
        run_op("ror1",     32'h0000_0001, 32'd1,   2'b11, 32'h8000_0000, 1'b0);
        run_op("ror7",     32'h0000_00F1, 32'd7,   2'b11, 32'hE200_0001, 1'b0);
`else
        run_op("mode3_srl", 32'h0000_0001, 32'd1,  2'b11, 32'h0000_0000, 1'b1);
        run_op("mode3_srl7", 32'h0000_00F1, 32'd7, 2'b11, 32'h0000_0001, 1'b0);
`endif

        // Backpressure: result held, no new request accepted while in DONE.
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 32'h0000_0005;
        in_amt   = 32'd3;
        in_mode  = 2'b00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 100) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check("bp_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 32'hFFFF_0000 + 32'(i);
            in_amt   = 32'(i);
            in_mode  = 2'b01;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            check("bp_hold_valid",  64'(out_valid),  64'd1);
            check("bp_hold_result", 64'(out_result), 64'h28);
            check("bp_hold_zero",   64'(out_zero),   64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_rel_valid",  64'(out_valid),  64'd0);
        check("bp_rel_ready",  64'(in_ready),   64'd1);
        check("bp_rel_result", 64'(out_result), 64'h28);

        // Reset in the middle of a long shift discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 32'hFFFF_FFFF;
        in_amt   = 32'd31;
        in_mode  = 2'b01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid",  64'(out_valid),  64'd0);
        check("mid_rst_result", 64'(out_result), 64'd0);
        check("mid_rst_ready",  64'(in_ready),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst_sll2", 32'h0000_0003, 32'd2, 2'b00, 32'h0000_000C, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
